// File: rtl/spi_flash_seq_if.sv
// WISHBONE register bus between spi_flash_seq (master) and the simple_spi core (slave).
interface spi_flash_seq_if;
  logic       m_cyc_o;
  logic       m_stb_o;
  logic       m_we_o;
  logic [1:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_ack_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/spi_flash_seq.sv
// Drives a simple_spi core over WISHBONE to run serial-flash commands: core init, CS-high
// dummy bytes, then per command an opcode/address header followed by optional read bytes.
module spi_flash_seq #(
  parameter logic [7:0]  SPCR_VAL    = 8'h50,
  parameter int unsigned DUMMY_BYTES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [7:0]      cmd_i,
  input  logic [23:0]     addr_i,
  input  logic            use_addr_i,
  input  logic [8:0]      len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [7:0]      rd_data_o,
  output logic            rd_valid_o,
  output logic            cs_b_o,
  spi_flash_seq_if.master m_bus
);

  localparam logic [1:0] AdrSpcr = 2'd0;
  localparam logic [1:0] AdrSpsr = 2'd1;
  localparam logic [1:0] AdrSpdr = 2'd2;

  typedef enum logic [2:0] {StInit, StDummy, StIdle, StHdr, StData, StFinish} state_e;
  typedef enum logic [1:0] {SubWr, SubPoll, SubRd} sub_e;

  state_e      r_state, w_state_d;
  sub_e        r_sub, w_sub_d;
  logic        r_cyc, w_cyc_d;
  logic        r_we, w_we_d;
  logic [1:0]  r_adr, w_adr_d;
  logic [7:0]  r_dat, w_dat_d;
  logic        r_cs_b, w_cs_b_d;
  logic        r_done, w_done_d;
  logic        r_rd_valid, w_rd_valid_d;
  logic [7:0]  r_rd_data, w_rd_data_d;
  logic [7:0]  r_cmd, w_cmd_d;
  logic [23:0] r_addr, w_addr_d;
  logic        r_use_addr, w_use_addr_d;
  logic [8:0]  r_cnt, w_cnt_d;
  logic [1:0]  r_hdr_idx, w_hdr_idx_d;

  logic        w_ack;
  logic        w_hdr_last;
  logic [7:0]  w_tx_byte;

  assign w_ack      = r_cyc & m_bus.m_ack_i;
  assign w_hdr_last = (r_hdr_idx == 2'd3) || (!r_use_addr && (r_hdr_idx == 2'd0));

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      StDummy: w_tx_byte = 8'hFF;
      StHdr: begin
        case (r_hdr_idx)
          2'd0:    w_tx_byte = r_cmd;
          2'd1:    w_tx_byte = r_addr[23:16];
          2'd2:    w_tx_byte = r_addr[15:8];
          default: w_tx_byte = r_addr[7:0];
        endcase
      end
      default: w_tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state_d    = r_state;
    w_sub_d      = r_sub;
    w_cyc_d      = r_cyc;
    w_we_d       = r_we;
    w_adr_d      = r_adr;
    w_dat_d      = r_dat;
    w_cs_b_d     = r_cs_b;
    w_done_d     = 1'b0;
    w_rd_valid_d = 1'b0;
    w_rd_data_d  = r_rd_data;
    w_cmd_d      = r_cmd;
    w_addr_d     = r_addr;
    w_use_addr_d = r_use_addr;
    w_cnt_d      = r_cnt;
    w_hdr_idx_d  = r_hdr_idx;

    case (r_state)
      StInit: begin
        if (!r_cyc) begin
          w_cyc_d = 1'b1;
          w_we_d  = 1'b1;
          w_adr_d = AdrSpcr;
          w_dat_d = SPCR_VAL;
        end else if (w_ack) begin
          w_cyc_d   = 1'b0;
          w_we_d    = 1'b0;
          w_sub_d   = SubWr;
          w_cnt_d   = 9'(DUMMY_BYTES);
          w_state_d = (DUMMY_BYTES == 0) ? StIdle : StDummy;
        end
      end

      StIdle: begin
        // r_done marks the completion cycle; it doubles as the mandatory gap before a new start
        if (start_i && !r_done) begin
          w_cmd_d      = cmd_i;
          w_addr_d     = addr_i;
          w_use_addr_d = use_addr_i;
          w_cnt_d      = (len_i > 9'd256) ? 9'd256 : len_i;
          w_hdr_idx_d  = 2'd0;
          w_sub_d      = SubWr;
          w_cs_b_d     = 1'b0;
          w_state_d    = StHdr;
        end
      end

      StDummy, StHdr, StData: begin
        if (!r_cyc) begin
          w_cyc_d = 1'b1;
          case (r_sub)
            SubWr: begin
              w_we_d  = 1'b1;
              w_adr_d = AdrSpdr;
              w_dat_d = w_tx_byte;
            end
            SubPoll: begin
              w_we_d  = 1'b0;
              w_adr_d = AdrSpsr;
              w_dat_d = 8'h00;
            end
            default: begin
              w_we_d  = 1'b0;
              w_adr_d = AdrSpdr;
              w_dat_d = 8'h00;
            end
          endcase
        end else if (w_ack) begin
          w_cyc_d = 1'b0;
          w_we_d  = 1'b0;
          case (r_sub)
            SubWr:   w_sub_d = SubPoll;
            SubPoll: if (!m_bus.m_dat_i[0]) w_sub_d = SubRd;
            default: begin
              // Byte complete: SPDR read data is on m_dat_i this cycle
              w_sub_d = SubWr;
              if (r_state == StHdr) begin
                if (w_hdr_last) w_state_d = (r_cnt == 9'd0) ? StFinish : StData;
                else w_hdr_idx_d = r_hdr_idx + 2'd1;
              end else begin
                if (r_state == StData) begin
                  w_rd_valid_d = 1'b1;
                  w_rd_data_d  = m_bus.m_dat_i;
                end
                if (r_cnt != 9'd0) w_cnt_d = r_cnt - 9'd1;
                if (r_cnt <= 9'd1) w_state_d = (r_state == StData) ? StFinish : StIdle;
              end
            end
          endcase
        end
      end

      StFinish: begin
        // Raise CS first, then report completion one cycle later
        if (!r_cs_b) begin
          w_cs_b_d = 1'b1;
        end else begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end

      default: w_state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StInit;
      r_sub      <= SubWr;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= 2'd0;
      r_dat      <= 8'h00;
      r_cs_b     <= 1'b1;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_cmd      <= 8'h00;
      r_addr     <= 24'h0;
      r_use_addr <= 1'b0;
      r_cnt      <= 9'd0;
      r_hdr_idx  <= 2'd0;
    end else begin
      r_state    <= w_state_d;
      r_sub      <= w_sub_d;
      r_cyc      <= w_cyc_d;
      r_we       <= w_we_d;
      r_adr      <= w_adr_d;
      r_dat      <= w_dat_d;
      r_cs_b     <= w_cs_b_d;
      r_done     <= w_done_d;
      r_rd_valid <= w_rd_valid_d;
      r_rd_data  <= w_rd_data_d;
      r_cmd      <= w_cmd_d;
      r_addr     <= w_addr_d;
      r_use_addr <= w_use_addr_d;
      r_cnt      <= w_cnt_d;
      r_hdr_idx  <= w_hdr_idx_d;
    end
  end

  assign m_bus.m_cyc_o = r_cyc;
  assign m_bus.m_stb_o = r_cyc;
  assign m_bus.m_we_o  = r_we;
  assign m_bus.m_adr_o = r_adr;
  assign m_bus.m_dat_o = r_dat;

  assign busy_o     = (r_state != StIdle) | r_done;
  assign done_o     = r_done;
  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;
  assign cs_b_o     = r_cs_b;

endmodule
